// File: rtl/mem_access_unit.sv
// Byte/halfword load-store sequencer in front of a byte-wide data memory.
// A 16-bit access is split into two single-byte memory cycles (low byte first).
module mem_access_unit #(
  parameter int unsigned LITTLE_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [7:0]  data_addr,
  output logic        ReadMem,
  output logic        WriteMem,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam bit LittleEndian = (LITTLE_ENDIAN != 0);

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] rdata_q, rdata_d;

  logic       accept;
  logic [7:0] addr_inc;
  logic [7:0] lo_addr;
  logic [7:0] hi_addr;

  assign accept   = (state_q == StIdle) && req_valid;
  assign addr_inc = addr_q + 8'd1;

  // The low byte always goes first; only its location depends on endianness.
  assign lo_addr = (word_q && !LittleEndian) ? addr_inc : addr_q;
  assign hi_addr = LittleEndian ? addr_inc : addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      lo_q    <= 8'h00;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StAcc0;
      StAcc0:  state_d = word_q ? StAcc1 : StResp;
      StAcc1:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch and read-data capture
  always_comb begin
    write_d = write_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;

    if (accept) begin
      write_d = req_write;
      word_d  = req_word;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end

    // resp_rdata only changes on the edge that enters StResp, so it holds between responses.
    unique case (state_q)
      StAcc0: begin
        if (!write_q) lo_d = mem_dout;
        if (!word_q) rdata_d = write_q ? 16'h0000 : {8'h00, mem_dout};
      end
      StAcc1:  rdata_d = write_q ? 16'h0000 : {mem_dout, lo_q};
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    data_addr  = 8'h00;
    ReadMem    = 1'b0;
    WriteMem   = 1'b0;
    mem_din    = 8'h00;

    unique case (state_q)
      StAcc0: begin
        data_addr = lo_addr;
        ReadMem   = !write_q && !reset;
        WriteMem  = write_q && !reset;
        mem_din   = wdata_q[7:0];
      end
      StAcc1: begin
        data_addr = hi_addr;
        ReadMem   = !write_q && !reset;
        WriteMem  = write_q && !reset;
        mem_din   = wdata_q[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: little- and big-endian instances driven in lockstep,
// each with its own byte memory, checked against an array-based reference model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        req_word;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        mem_clr;

  logic        rdy_le, rdy_be, rv_le, rv_be, rd_le, rd_be, wr_le, wr_be;
  logic [15:0] rdata_le, rdata_be;
  logic [7:0]  addr_le, addr_be, din_le, din_be, dout_le, dout_be;

  logic [7:0] mem_le [256];
  logic [7:0] mem_be [256];
  logic [7:0] ref_le [256];
  logic [7:0] ref_be [256];

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.LITTLE_ENDIAN(1)) u_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_le),
    .req_write(req_write), .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_le), .resp_rdata(rdata_le), .data_addr(addr_le), .ReadMem(rd_le),
    .WriteMem(wr_le), .mem_din(din_le), .mem_dout(dout_le)
  );

  mem_access_unit #(.LITTLE_ENDIAN(0)) u_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_be),
    .req_write(req_write), .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_be), .resp_rdata(rdata_be), .data_addr(addr_be), .ReadMem(rd_be),
    .WriteMem(wr_be), .mem_din(din_be), .mem_dout(dout_be)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Junk on the data bus whenever the memory is not being read.
  assign dout_le = rd_le ? mem_le[addr_le] : 8'hEE;
  assign dout_be = rd_be ? mem_be[addr_be] : 8'hEE;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_le[i] <= init_val(i);
        mem_be[i] <= init_val(i);
      end
    end else begin
      if (wr_le) mem_le[addr_le] <= din_le;
      if (wr_be) mem_be[addr_be] <= din_be;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge with both units idle; returns at the negedge after the response.
  task automatic do_req(input logic wr, input logic wd, input logic [7:0] a,
                        input logic [15:0] wdat, output logic [15:0] got_le,
                        output logic [15:0] got_be);
    logic [7:0]  a1;
    logic [7:0]  ea_le [2];
    logic [7:0]  ea_be [2];
    logic [7:0]  ed [2];
    logic [7:0]  la_le [4];
    logic [7:0]  ld_le [4];
    logic [7:0]  la_be [4];
    logic [7:0]  ld_be [4];
    logic [1:0]  lk_le [4];
    logic [1:0]  lk_be [4];
    logic [15:0] exp_le, exp_be;
    int          n_exp, n_le, n_be, lat_le, lat_be;

    a1 = a + 8'd1;
    n_exp = wd ? 2 : 1;
    ea_le = '{a, a1};
    ea_be = wd ? '{a1, a} : '{a, a1};
    ed    = '{wdat[7:0], wdat[15:8]};
    if (wr) begin
      exp_le = 16'h0000;
      exp_be = 16'h0000;
      if (wd) begin
        ref_le[a] = wdat[7:0];  ref_le[a1] = wdat[15:8];
        ref_be[a] = wdat[15:8]; ref_be[a1] = wdat[7:0];
      end else begin
        ref_le[a] = wdat[7:0];
        ref_be[a] = wdat[7:0];
      end
    end else if (wd) begin
      exp_le = {ref_le[a1], ref_le[a]};
      exp_be = {ref_be[a], ref_be[a1]};
    end else begin
      exp_le = {8'h00, ref_le[a]};
      exp_be = {8'h00, ref_be[a]};
    end

    chk("ready_before_req", {30'd0, rdy_le, rdy_be}, 32'd3);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_addr  = a;
    req_wdata = wdat;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1);
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);

    n_le = 0; n_be = 0; lat_le = 0; lat_be = 0;
    got_le = 16'hxxxx; got_be = 16'hxxxx;
    for (int c = 1; c <= 6 && (lat_le == 0 || lat_be == 0); c++) begin
      if (c > 1) @(negedge clk);
      if (lat_le == 0) begin
        if (rv_le) begin
          lat_le = c;
          got_le = rdata_le;
          chk("le_resp_idle_bus", {rdy_le, rd_le, wr_le, addr_le, din_le}, 32'd0);
        end else if ((rd_le || wr_le) && n_le < 4) begin
          la_le[n_le] = addr_le; ld_le[n_le] = din_le; lk_le[n_le] = {rd_le, wr_le};
          n_le++;
        end
      end
      if (lat_be == 0) begin
        if (rv_be) begin
          lat_be = c;
          got_be = rdata_be;
          chk("be_resp_idle_bus", {rdy_be, rd_be, wr_be, addr_be, din_be}, 32'd0);
        end else if ((rd_be || wr_be) && n_be < 4) begin
          la_be[n_be] = addr_be; ld_be[n_be] = din_be; lk_be[n_be] = {rd_be, wr_be};
          n_be++;
        end
      end
    end

    chk("le_latency", lat_le, wd ? 3 : 2);
    chk("be_latency", lat_be, wd ? 3 : 2);
    chk("le_access_count", n_le, n_exp);
    chk("be_access_count", n_be, n_exp);
    for (int i = 0; i < n_exp && i < n_le; i++) begin
      chk("le_access_addr", la_le[i], ea_le[i]);
      chk("le_access_kind", lk_le[i], wr ? 2'b01 : 2'b10);
      if (wr) chk("le_access_wdata", ld_le[i], ed[i]);
    end
    for (int i = 0; i < n_exp && i < n_be; i++) begin
      chk("be_access_addr", la_be[i], ea_be[i]);
      chk("be_access_kind", lk_be[i], wr ? 2'b01 : 2'b10);
      if (wr) chk("be_access_wdata", ld_be[i], ed[i]);
    end
    chk("le_rdata", got_le, exp_le);
    chk("be_rdata", got_be, exp_be);

    @(negedge clk);
    chk("after_resp_ready_valid", {28'd0, rdy_le, rdy_be, rv_le, rv_be}, 32'hC);
    chk("le_rdata_hold", rdata_le, exp_le);
    chk("be_rdata_hold", rdata_be, exp_be);
  endtask

  typedef struct {
    logic        wr;
    logic        wd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_le;
    logic [15:0] exp_be;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] g_le, g_be;
    int          accepts, diffs;

    vecs[0]  = '{1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 16'h00A5};
    vecs[2]  = '{1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 16'h1234};
    vecs[6]  = '{1'b1, 1'b1, 8'h30, 16'hCAFE, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 8'h30, 16'h0000, 16'h00FE, 16'h00CA};
    vecs[8]  = '{1'b0, 1'b0, 8'h31, 16'h0000, 16'h00CA, 16'h00FE};
    vecs[9]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0034, 16'h0012};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0012, 16'h0034};

    for (int i = 0; i < 256; i++) begin
      ref_le[i] = init_val(i);
      ref_be[i] = init_val(i);
    end

    reset = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;
    #1;
    chk("rst_le_ready_valid", {rdy_le, rv_le}, 2'b10);
    chk("rst_be_ready_valid", {rdy_be, rv_be}, 2'b10);
    chk("rst_le_mem_side", {rd_le, wr_le, addr_le, din_le}, 32'd0);
    chk("rst_be_mem_side", {rd_be, wr_be, addr_be, din_be}, 32'd0);
    chk("rst_rdata", {rdata_le, rdata_be}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].wr, vecs[i].wd, vecs[i].addr, vecs[i].wdata, g_le, g_be);
      chk($sformatf("vec%0d_le", i), g_le, vecs[i].exp_le);
      chk($sformatf("vec%0d_be", i), g_be, vecs[i].exp_be);
    end
    chk("le_mem_20_21", {mem_le[8'h21], mem_le[8'h20]}, 16'hBEEF);
    chk("le_mem_ff_00", {mem_le[8'h00], mem_le[8'hFF]}, 16'h1234);
    chk("be_mem_30_31", {mem_be[8'h30], mem_be[8'h31]}, 16'hCAFE);
    chk("le_mem_10", mem_le[8'h10], 8'hA5);

    // Back-to-back byte loads with req_valid held high.
    accepts = 0;
    req_valid = 1'b1; req_write = 1'b0; req_word = 1'b0; req_addr = 8'h10;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stream_ready_%0d", k), {rdy_le, rdy_be}, (k % 3 == 0) ? 2'b11 : 2'b00);
      chk($sformatf("stream_resp_%0d", k), {rv_le, rv_be}, (k % 3 == 2) ? 2'b11 : 2'b00);
      if (rdy_le) accepts++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stream_accepts", accepts, 4);
    for (int k = 0; k < 6 && !(rdy_le && rdy_be); k++) @(negedge clk);
    chk("stream_drained", {rdy_le, rdy_be}, 2'b11);

    // Reset during the second byte of a word store.
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1; req_addr = 8'h40;
    req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_gates_write", {wr_le, wr_be, rd_le, rd_be}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", {rdy_le, rdy_be}, 2'b11);
    chk("abort_rdata", {rdata_le, rdata_be}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_resp", {rv_le, rv_be}, 2'b00);
      @(negedge clk);
    end
    ref_le[8'h40] = 8'h34;
    ref_be[8'h41] = 8'h34;
    chk("abort_le_40", mem_le[8'h40], 8'h34);
    chk("abort_le_41", mem_le[8'h41], init_val(8'h41));
    chk("abort_be_40", mem_be[8'h40], init_val(8'h40));
    chk("abort_be_41", mem_be[8'h41], 8'h34);

    // Random traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom), g_le,
             g_be);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_le[i] !== ref_le[i]) diffs++;
      if (mem_be[i] !== ref_be[i]) diffs++;
    end
    chk("final_memory_diffs", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: LITTLE_ENDIAN, default 1, 1 = low byte at addr and high byte at addr+1; 0 = high byte at addr and low byte at addr+1.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline presents an access request.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_word  in  1  1 = 16-bit access (two bytes), 0 = 8-bit access.
REQ-008 req_addr  in  8  byte address.
REQ-009 req_wdata  in  16  store data; only bits [7:0] are used for byte stores.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  16  load result, valid while resp_valid is high.
REQ-012 data_addr  out  8  data memory address.
REQ-013 ReadMem  out  1  data memory read enable; memory read data is combinational and valid in the same cycle.
REQ-014 WriteMem  out  1  data memory write enable; the memory writes on the posedge at the end of the cycle.
REQ-015 mem_din  out  8  byte driven to the memory data input.
REQ-016 mem_dout  in  8  byte returned by memory; undefined or Z when ReadMem=0, and must never be sampled then.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ACC0, ACC1, RESP.
REQ-018 IDLE: req_ready=1; on req_valid=1, latch write, word, addr, wdata and go to ACC0; otherwise stay in IDLE.
REQ-019 Outside IDLE, req_ready SHALL be 0; req_valid is ignored.
REQ-020 ACC0: data_addr = latched addr (or addr+1 for a word with LITTLE_ENDIAN=0); ReadMem = !write; WriteMem = write; mem_din = first byte.
REQ-021 ACC0 exit: a word access goes to ACC1; a byte access goes to RESP.
REQ-022 ACC1: access the other byte of the word; the address of the second byte is (addr+1) mod 256.
REQ-023 Address wrap: a word access at 0xFF SHALL access bytes 0xFF and 0x00.
REQ-024 ACC1 exit: go to RESP.
REQ-025 Read capture: in each read access state, register mem_dout at the closing edge into the correct byte lane.
REQ-026 RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
REQ-027 resp_rdata for a byte load SHALL be {8'h00, byte}.
REQ-028 resp_rdata for any store SHALL be 16'h0000.
REQ-029 resp_rdata SHALL hold its value until the next RESP; it is 16'h0000 after reset.
REQ-030 In IDLE and RESP: ReadMem=0, WriteMem=0, data_addr=8'h00, mem_din=8'h00.
REQ-031 Latency: request accepted at edge N gives resp_valid in cycle N+2 for a byte access and N+3 for a word access.
REQ-032 The next request can be accepted in the cycle after resp_valid.
REQ-033 No more than one memory access SHALL occur per cycle; no access SHALL occur without an accepted request.

Reset
REQ-034 A reset sampled high SHALL force state=IDLE and resp_rdata=16'h0000 at that edge.
REQ-035 ReadMem and WriteMem SHALL be gated by !reset, so no memory write occurs on any edge where reset is high.
REQ-036 After reset release: req_ready=1, resp_valid=0, and all memory-side outputs are 0.
REQ-037 Reset mid-word: bytes already written stay written, the remaining byte is not written, and no resp_valid is produced for the aborted request.

Verification
REQ-038 Byte store addr=0x10 data=0x00A5, then byte load 0x10 -> exactly one WriteMem pulse at 0x10 with mem_din=0xA5; load returns resp_rdata=0x00A5 at N+2.
REQ-039 Word store addr=0x20 data=0xBEEF (LE), then word load 0x20 -> memory holds [0x20]=0xEF and [0x21]=0xBE; load returns 0xBEEF at N+3.
REQ-040 Word load at 0xFF with [0xFF]=0x34 and [0x00]=0x12, LITTLE_ENDIAN=1 -> data_addr sequence 0xFF, 0x00; resp_rdata=0x1234.
REQ-041 req_valid held high for 10 cycles with byte requests -> one accept every 3 cycles; req_ready=0 in ACC0 and RESP.
REQ-042 Reset asserted in ACC1 of word store 0x1234 to 0x40 -> [0x40]=0x34 written, [0x41] unchanged, no resp_valid, req_ready=1 the cycle after reset drops.
REQ-043 Word store with LITTLE_ENDIAN=0 of 0xCAFE at 0x30 -> [0x30]=0xCA and [0x31]=0xFE.
